// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned MULTU/DIVU,
// with results in registered LO/HI outputs and a start/busy/done handshake.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled at a rising edge only while busy==0; done pulses
  // for one cycle and result_lo/result_hi/div_zero are valid from that cycle on,
  // holding until the next done or reset.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam logic [3:0] F_AND   = 4'b0000;
  localparam logic [3:0] F_OR    = 4'b0001;
  localparam logic [3:0] F_ADD   = 4'b0010;
  localparam logic [3:0] F_SUB   = 4'b0110;
  localparam logic [3:0] F_SLT   = 4'b0111;
  localparam logic [3:0] F_MULTU = 4'b1000;
  localparam logic [3:0] F_DIVU  = 4'b1001;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opr;     // multiplicand or divisor
  logic [WIDTH-1:0] acc_hi;  // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;  // multiplier shifting out / dividend becoming quotient
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] alu_res;
  logic             last;

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign last      = (cnt == LAST_STEP);

  always_comb begin
    alu_res = '0;
    case (func)
      F_AND:   alu_res = inp1 & inp2;
      F_OR:    alu_res = inp1 | inp2;
      F_ADD:   alu_res = inp1 + inp2;
      F_SUB:   alu_res = inp1 - inp2;
      F_SLT:   alu_res = (inp1 < inp2) ? '1 : '0;
      default: alu_res = '0;
    endcase
  end

  // One iteration of either shift-add multiply or restoring divide.
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opr} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opr};
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    if (state == MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (state == DIV) begin
      // A zero divisor never borrows, so the quotient fills with ones and the
      // remainder ends up as the dividend.
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && func == F_MULTU)     state_nxt = MUL;
        else if (start && func == F_DIVU) state_nxt = DIV;
      end
      MUL, DIV: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      opr       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (func == F_MULTU) begin
              opr    <= inp1;
              acc_hi <= '0;
              acc_lo <= inp2;
              cnt    <= '0;
            end else if (func == F_DIVU) begin
              opr    <= inp2;
              acc_hi <= '0;
              acc_lo <= inp1;
              cnt    <= '0;
            end else begin
              result_lo <= alu_res;
              result_hi <= '0;
              div_zero  <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (last) begin
            cnt       <= '0;
            result_lo <= step_lo;
            result_hi <= step_hi;
            div_zero  <= (state == DIV) && (opr == '0);
            done      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: scoreboard of {div_zero, hi, lo} per request,
// plus latency, busy-length, hold, back-to-back and mid-operation reset checks.
module tb_alu_multicycle;

  localparam int W  = 32;
  localparam int EW = 2 * W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   func = 4'b0000;
  logic [W-1:0] inp1 = '0;
  logic [W-1:0] inp2 = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] result_lo, result_hi;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  alu_multicycle #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func),
    .inp1(inp1), .inp2(inp2), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi),
    .div_zero(div_zero), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic [3:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [W-1:0]   ones;
    ones = '1;
    model = '0;
    case (f)
      4'b0000: model = {1'b0, {W{1'b0}}, a & b};
      4'b0001: model = {1'b0, {W{1'b0}}, a | b};
      4'b0010: model = {1'b0, {W{1'b0}}, a + b};
      4'b0110: model = {1'b0, {W{1'b0}}, a - b};
      4'b0111: model = {1'b0, {W{1'b0}}, (a < b) ? ones : {W{1'b0}}};
      4'b1000: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        model = {1'b0, p};
      end
      4'b1001: begin
        if (b == '0) model = {1'b1, a, ones};
        else         model = {1'b0, a % b, a / b};
      end
      default: model = '0;
    endcase
  endfunction

  // scoreboard: every done must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done: observed=done with empty queue expected=no done");
      end
      if (exp_q.size() != 0) check("result", {div_zero, result_hi, result_lo}, exp_q.pop_front());
    end
  end

  // driver: issue one request, measure latency and busy length, then check hold
  task automatic do_op(input string tag, input logic [3:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int lat, input int inj);
    int n;
    int bc;
    bit seen;
    logic [EW-1:0] e;
    e = model(f, a, b);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1; func = f; inp1 = a; inp2 = b;
    n = 0; bc = 0; seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (inj != 0 && n == inj) begin
        start = 1'b1; func = 4'b0110; inp1 = $urandom; inp2 = $urandom;
      end
      if (inj != 0 && n == inj + 1) start = 1'b0;
      if (busy) bc++;
      seen = done;
    end
    check({tag, "_latency"}, EW'(n), EW'(lat));
    check({tag, "_busy_cycles"}, EW'(bc), EW'(lat - 1));
    @(negedge clk);
    check({tag, "_done_single"}, EW'(done), EW'(0));
    check({tag, "_hold"}, {div_zero, result_hi, result_lo}, e);
  endtask

  initial begin : stim
    int dn;
    logic [3:0] fl [9];
    logic [3:0] f;
    fl = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011, 4'b1000, 4'b1001, 4'b1111};

    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, div_zero, result_hi, result_lo}, '0);
    check("reset_state", EW'(state_dbg), EW'(0));
    rst = 1'b0;

    // 1. ADD wraps to zero
    do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 1, 0);

    // 2. back-to-back SLT
    @(negedge clk);
    exp_q.push_back(model(4'b0111, 32'd3, 32'd5));
    start = 1'b1; func = 4'b0111; inp1 = 32'd3; inp2 = 32'd5;
    @(negedge clk);
    check("slt_b2b_done1", EW'(done), EW'(1));
    exp_q.push_back(model(4'b0111, 32'd5, 32'd3));
    inp1 = 32'd5; inp2 = 32'd3;
    @(negedge clk);
    check("slt_b2b_done2", EW'(done), EW'(1));
    start = 1'b0;
    @(negedge clk);
    check("slt_b2b_done3", EW'(done), EW'(0));
    check("slt_b2b_lo", EW'(result_lo), EW'(0));

    // 3. MULTU max * max
    do_op("multu_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 1, 0);
    check("multu_max_value", {result_hi, result_lo}, EW'(64'hFFFF_FFFE_0000_0001));

    // 4. DIVU with an ignored start mid-operation
    do_op("divu_ignore", 4'b1001, 32'd100, 32'd7, W + 1, 5);
    check("divu_value", {div_zero, result_hi, result_lo}, {1'b0, 32'd2, 32'd14});

    // 5. DIVU by zero
    do_op("divu_zero", 4'b1001, 32'h1234, 32'h0, W + 1, 0);
    check("divu_zero_value", {div_zero, result_hi, result_lo}, {1'b1, 32'h1234, 32'hFFFF_FFFF});

    // 6. reset in the middle of MULTU
    @(negedge clk);
    start = 1'b1; func = 4'b1000; inp1 = 32'h1234_5678; inp2 = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {busy, done, div_zero, result_hi, result_lo}, '0);
    check("rst_mid_state", EW'(state_dbg), EW'(0));
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("rst_mid_no_done", EW'(dn), EW'(0));
    do_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 1, 0);
    check("add_after_rst_value", EW'(result_lo), EW'(5));

    // random mix over all opcodes, including undefined ones
    for (int i = 0; i < 10; i++) begin
      f = fl[$urandom_range(0, 8)];
      do_op("random", f, $urandom, $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom,
            (f == 4'b1000 || f == 4'b1001) ? W + 1 : 1, 0);
    end

    check("queue_drained", EW'(exp_q.size()), EW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
